// File: rtl/branch_cmp_pipe_if.sv
// Request/result bundle between decode/forwarding and PC-select for branch_cmp_pipe.
// The master modport is the issuing side; the slave modport is the branch unit itself.
interface branch_cmp_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] pc;
    logic              pred_taken;
    logic              out_valid;
    logic              out_ready;
    logic              taken;
    logic              is_link;
    logic [DATA_W-1:0] link_addr;
    logic              mispredict;
    logic [31:0]       br_cnt;
    logic [31:0]       mp_cnt;

    modport master (
        output in_valid, op, a, b, pc, pred_taken, out_ready,
        input  in_ready, out_valid, taken, is_link, link_addr, mispredict, br_cnt, mp_cnt
    );

    modport slave (
        input  in_valid, op, a, b, pc, pred_taken, out_ready,
        output in_ready, out_valid, taken, is_link, link_addr, mispredict, br_cnt, mp_cnt
    );
endinterface

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch-condition unit: resolves the branch, computes pc+8 and flags mispredicts.
// Optional BRANCH_CMP_STATS_EN adds saturating resolved-branch and mispredict counters.
module branch_cmp_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input logic              clk,
    input logic              resetn,
    input logic              flush,
    branch_cmp_pipe_if.slave bus
);
    localparam logic [7:0] OP_BEQ    = 8'h01;
    localparam logic [7:0] OP_BNE    = 8'h02;
    localparam logic [7:0] OP_BGTZ   = 8'h03;
    localparam logic [7:0] OP_BLEZ   = 8'h04;
    localparam logic [7:0] OP_BLTZ   = 8'h05;
    localparam logic [7:0] OP_BLTZAL = 8'h06;
    localparam logic [7:0] OP_BGEZ   = 8'h07;
    localparam logic [7:0] OP_BGEZAL = 8'h08;

    typedef struct packed {
        logic              eq;
        logic              aNeg;
        logic              aZero;
        logic [7:0]        op;
        logic              pred;
        logic [DATA_W-1:0] link;
    } flags_t;

    generate
        if (DATA_W < 8) begin : g_badWidth
            $error("branch_cmp_pipe: DATA_W must be at least 8");
        end
        if (STAGES != 1 && STAGES != 2) begin : g_badStages
            $error("branch_cmp_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    function automatic logic decideTaken(flags_t f);
        logic cond;
        cond = 1'b0;
        case (f.op)
            OP_BEQ:              cond = f.eq;
            OP_BNE:              cond = !f.eq;
            OP_BGTZ:             cond = !f.aNeg && !f.aZero;
            OP_BLEZ:             cond = f.aNeg || f.aZero;
            OP_BLTZ, OP_BLTZAL:  cond = f.aNeg;
            OP_BGEZ, OP_BGEZAL:  cond = !f.aNeg;
            default:             cond = 1'b0;
        endcase
        return cond;
    endfunction

    flags_t            inFlags;
    flags_t            srcFlags;
    logic              srcValid;
    logic              inReady;
    logic              outAccept;
    logic              outLoad;
    logic              outValid_q, outValid_d;
    logic              taken_q, taken_d;
    logic              isLink_q, isLink_d;
    logic              mispredict_q, mispredict_d;
    logic [DATA_W-1:0] link_q, link_d;

    always_comb begin
        inFlags.eq    = (bus.a == bus.b);
        inFlags.aNeg  = bus.a[DATA_W-1];
        inFlags.aZero = (bus.a == '0);
        inFlags.op    = bus.op;
        inFlags.pred  = bus.pred_taken;
        inFlags.link  = bus.pc + DATA_W'(8);
    end

    assign outAccept = !outValid_q || bus.out_ready;

    // With two stages the flags are latched first; with one stage they feed the decision directly.
    generate
        if (STAGES == 2) begin : g_twoStage
            logic   st1Valid_q, st1Valid_d;
            flags_t st1Flags_q, st1Flags_d;

            assign inReady = !flush && (!st1Valid_q || outAccept);

            always_comb begin
                st1Valid_d = st1Valid_q;
                st1Flags_d = st1Flags_q;
                if (flush) begin
                    st1Valid_d = 1'b0;
                end else if (inReady) begin
                    st1Valid_d = bus.in_valid;
                    if (bus.in_valid) begin
                        st1Flags_d = inFlags;
                    end
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    st1Valid_q <= 1'b0;
                    st1Flags_q <= '0;
                end else begin
                    st1Valid_q <= st1Valid_d;
                    st1Flags_q <= st1Flags_d;
                end
            end

            assign srcValid = st1Valid_q;
            assign srcFlags = st1Flags_q;
        end else begin : g_oneStage
            assign inReady  = !flush && outAccept;
            assign srcValid = bus.in_valid;
            assign srcFlags = inFlags;
        end
    endgenerate

    assign outLoad = !flush && outAccept && srcValid;

    always_comb begin
        outValid_d   = outValid_q;
        taken_d      = taken_q;
        isLink_d     = isLink_q;
        mispredict_d = mispredict_q;
        link_d       = link_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else if (outAccept) begin
            outValid_d = srcValid;
        end
        if (outLoad) begin
            taken_d      = decideTaken(srcFlags);
            isLink_d     = (srcFlags.op == OP_BLTZAL) || (srcFlags.op == OP_BGEZAL);
            mispredict_d = decideTaken(srcFlags) ^ srcFlags.pred;
            link_d       = srcFlags.link;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outValid_q   <= 1'b0;
            taken_q      <= 1'b0;
            isLink_q     <= 1'b0;
            mispredict_q <= 1'b0;
            link_q       <= '0;
        end else begin
            outValid_q   <= outValid_d;
            taken_q      <= taken_d;
            isLink_q     <= isLink_d;
            mispredict_q <= mispredict_d;
            link_q       <= link_d;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid_q;
    assign bus.taken      = taken_q;
    assign bus.is_link    = isLink_q;
    assign bus.mispredict = mispredict_q;
    assign bus.link_addr  = link_q;

`ifdef BRANCH_CMP_STATS_EN
    logic        known_q, known_d;
    logic        countFire;
    logic [31:0] brCnt_q, brCnt_d;
    logic [31:0] mpCnt_q, mpCnt_d;

    // A transfer in a flush cycle is dropped by the pipe, so it is not counted either.
    assign countFire = outValid_q && bus.out_ready && !flush && known_q;

    always_comb begin
        known_d = known_q;
        brCnt_d = brCnt_q;
        mpCnt_d = mpCnt_q;
        if (outLoad) begin
            case (srcFlags.op)
                OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ,
                OP_BLTZ, OP_BLTZAL, OP_BGEZ, OP_BGEZAL: known_d = 1'b1;
                default:                                known_d = 1'b0;
            endcase
        end
        if (countFire && (brCnt_q != 32'hFFFF_FFFF)) begin
            brCnt_d = brCnt_q + 32'd1;
        end
        if (countFire && mispredict_q && (mpCnt_q != 32'hFFFF_FFFF)) begin
            mpCnt_d = mpCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            known_q <= 1'b0;
            brCnt_q <= '0;
            mpCnt_q <= '0;
        end else begin
            known_q <= known_d;
            brCnt_q <= brCnt_d;
            mpCnt_q <= mpCnt_d;
        end
    end

    assign bus.br_cnt = brCnt_q;
    assign bus.mp_cnt = mpCnt_q;
`else
    assign bus.br_cnt = '0;
    assign bus.mp_cnt = '0;
`endif
endmodule
